// File: rtl/axi_slv_resp_engine_if.sv
// AXI slave response engine bus: AW/W/B/AR/R handshake signals.
// Ports: master drives valids/request fields, slave drives readies/responses.
interface axi_slv_resp_engine_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              awvalid;
  logic              awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic              wvalid;
  logic              wready;
  logic              wlast;
  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output awvalid, awid, awaddr, awlen,
    output wvalid, wlast, bready,
    output arvalid, arid, araddr, arlen,
    output rready,
    input  awready, wready,
    input  bvalid, bid, bresp,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen,
    input  wvalid, wlast, bready,
    input  arvalid, arid, araddr, arlen,
    input  rready,
    output awready, wready,
    output bvalid, bid, bresp,
    output arready,
    output rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi_slv_resp_engine.sv
// AXI slave response engine: accepts AW/W/AR, returns B and address-pattern R.
// Ports: aclk, aresetn, bus (slave modport), wr_ostd/rd_ostd outstanding counts.
module axi_slv_resp_engine #(
  parameter int                    AXI_ADDR_W    = 32,
  parameter int                    AXI_ID_W      = 4,
  parameter int                    AXI_DATA_W    = 32,
  parameter int                    OSTD_NUM      = 4,
  parameter int                    READY_MODE    = 0,
  parameter logic [15:0]           LFSR_SEED     = 16'hACE1,
  parameter logic [AXI_ADDR_W-1:0] ERR_ADDR_BASE = {AXI_ADDR_W{1'b1}}
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  axi_slv_resp_engine_if.slave      bus,
  output logic [$clog2(OSTD_NUM):0] wr_ostd,
  output logic [$clog2(OSTD_NUM):0] rd_ostd
);
  localparam int PW    = $clog2(OSTD_NUM);
  localparam int CW    = PW + 1;
  localparam int BYTES = AXI_DATA_W / 8;

  logic [15:0] lfsr;
  logic        gate_aw;
  logic        gate_w;
  logic        gate_ar;

  logic [AXI_ID_W-1:0] w_id   [OSTD_NUM];
  logic [3:0]          w_len  [OSTD_NUM];
  logic                w_aerr [OSTD_NUM];
  logic                w_derr [OSTD_NUM];
  logic [PW-1:0]       aw_ptr;
  logic [PW-1:0]       wd_ptr;
  logic [PW-1:0]       b_ptr;
  logic [CW-1:0]       dp_cnt;
  logic [CW-1:0]       bq_cnt;
  logic [3:0]          w_beat;

  logic [AXI_ID_W-1:0]   r_id   [OSTD_NUM];
  logic [AXI_ADDR_W-1:0] r_addr [OSTD_NUM];
  logic [3:0]            r_len  [OSTD_NUM];
  logic                  r_err  [OSTD_NUM];
  logic [PW-1:0]         ar_ptr;
  logic [PW-1:0]         r_ptr;
  logic [3:0]            r_beat;

  logic awready, wready, arready;
  logic bvalid, rvalid, rlast;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic w_end, w_close, r_done;

  assign gate_aw = (READY_MODE == 0) ? 1'b1 : lfsr[0];
  assign gate_w  = (READY_MODE == 0) ? 1'b1 : lfsr[5];
  assign gate_ar = (READY_MODE == 0) ? 1'b1 : lfsr[10];

  // Full checks use registered counts only: a completion in
  // the same cycle does not open a slot until the next cycle.
  assign awready = aresetn && gate_aw && (wr_ostd < CW'(OSTD_NUM));
  assign wready  = aresetn && gate_w && (dp_cnt != '0);
  assign arready = aresetn && gate_ar && (rd_ostd < CW'(OSTD_NUM));
  assign bvalid  = (bq_cnt != '0);
  assign rvalid  = (rd_ostd != '0);
  assign rlast   = rvalid && (r_beat == r_len[r_ptr]);

  assign aw_hs = bus.awvalid && awready;
  assign w_hs  = bus.wvalid && wready;
  assign b_hs  = bvalid && bus.bready;
  assign ar_hs = bus.arvalid && arready;
  assign r_hs  = rvalid && bus.rready;

  // A burst closes on wlast or at its last expected beat.
  assign w_end   = (w_beat == w_len[wd_ptr]);
  assign w_close = w_hs && (bus.wlast || w_end);
  assign r_done  = r_hs && rlast;

  assign bus.awready = awready;
  assign bus.wready  = wready;
  assign bus.arready = arready;
  assign bus.bvalid  = bvalid;
  assign bus.bid     = w_id[b_ptr];
  assign bus.bresp   = (w_aerr[b_ptr] || w_derr[b_ptr]) ? 2'b10 : 2'b00;
  assign bus.rvalid  = rvalid;
  assign bus.rid     = r_id[r_ptr];
  assign bus.rresp   = r_err[r_ptr] ? 2'b10 : 2'b00;
  assign bus.rlast   = rlast;
  assign bus.rdata   = AXI_DATA_W'(r_addr[r_ptr])
                     + AXI_DATA_W'(r_beat) * AXI_DATA_W'(BYTES);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr    <= LFSR_SEED;
      aw_ptr  <= '0;
      wd_ptr  <= '0;
      b_ptr   <= '0;
      dp_cnt  <= '0;
      bq_cnt  <= '0;
      w_beat  <= '0;
      wr_ostd <= '0;
      ar_ptr  <= '0;
      r_ptr   <= '0;
      r_beat  <= '0;
      rd_ostd <= '0;
      for (int i = 0; i < OSTD_NUM; i++) begin
        w_id[i]   <= '0;
        w_len[i]  <= '0;
        w_aerr[i] <= 1'b0;
        w_derr[i] <= 1'b0;
        r_id[i]   <= '0;
        r_addr[i] <= '0;
        r_len[i]  <= '0;
        r_err[i]  <= 1'b0;
      end
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5],
               lfsr[15:1]};

      if (aw_hs) begin
        w_id[aw_ptr]   <= bus.awid;
        w_len[aw_ptr]  <= bus.awlen;
        w_aerr[aw_ptr] <= (bus.awaddr >= ERR_ADDR_BASE);
        aw_ptr         <= aw_ptr + PW'(1);
      end

      if (w_hs) begin
        if (w_close) begin
          w_derr[wd_ptr] <= (bus.wlast != w_end);
          wd_ptr         <= wd_ptr + PW'(1);
          w_beat         <= '0;
        end else begin
          w_beat <= w_beat + 4'd1;
        end
      end

      if (b_hs) begin
        b_ptr <= b_ptr + PW'(1);
      end

      wr_ostd <= wr_ostd + CW'(aw_hs) - CW'(b_hs);
      dp_cnt  <= dp_cnt + CW'(aw_hs) - CW'(w_close);
      bq_cnt  <= bq_cnt + CW'(w_close) - CW'(b_hs);

      if (ar_hs) begin
        r_id[ar_ptr]   <= bus.arid;
        r_addr[ar_ptr] <= bus.araddr;
        r_len[ar_ptr]  <= bus.arlen;
        r_err[ar_ptr]  <= (bus.araddr >= ERR_ADDR_BASE);
        ar_ptr         <= ar_ptr + PW'(1);
      end

      if (r_hs) begin
        if (rlast) begin
          r_ptr  <= r_ptr + PW'(1);
          r_beat <= '0;
        end else begin
          r_beat <= r_beat + 4'd1;
        end
      end

      rd_ostd <= rd_ostd + CW'(ar_hs) - CW'(r_done);
    end
  end
endmodule

// File: tb/tb_axi_slv_resp_engine.sv
// Testbench for axi_slv_resp_engine: directed vectors on a mode-0 instance
// and a cycle-exact ready pattern check on an LFSR-throttled instance.
module tb_axi_slv_resp_engine;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 aclk = ~aclk;

  axi_slv_resp_engine_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) ifa ();
  axi_slv_resp_engine_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) ifb ();

  logic [2:0] wr_ostd_a, rd_ostd_a;
  logic [2:0] wr_ostd_b, rd_ostd_b;

  axi_slv_resp_engine #(
    .AXI_ADDR_W(32), .AXI_ID_W(4), .AXI_DATA_W(32),
    .OSTD_NUM(4), .READY_MODE(0),
    .ERR_ADDR_BASE(32'h0000_8000)
  ) dut_a (
    .aclk(aclk), .aresetn(aresetn), .bus(ifa),
    .wr_ostd(wr_ostd_a), .rd_ostd(rd_ostd_a)
  );

  axi_slv_resp_engine #(
    .AXI_ADDR_W(32), .AXI_ID_W(4), .AXI_DATA_W(32),
    .OSTD_NUM(4), .READY_MODE(1), .LFSR_SEED(16'hACE1)
  ) dut_b (
    .aclk(aclk), .aresetn(aresetn), .bus(ifb),
    .wr_ostd(wr_ostd_b), .rd_ostd(rd_ostd_b)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [31:0] d [4];
    logic [1:0]  resp;
  } rvec_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    int          nbeats;
    int          lastpos;
    logic [1:0]  resp;
  } wvec_t;

  rvec_t rv [4];
  wvec_t wv [6];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [3:0] len,
                       input logic [31:0] addr);
    ifa.awvalid = 1'b1;
    ifa.awid    = id;
    ifa.awlen   = len;
    ifa.awaddr  = addr;
    #1;
    chk("awready", ifa.awready, 1);
    @(negedge aclk);
    ifa.awvalid = 1'b0;
  endtask

  task automatic do_w(input logic last);
    ifa.wvalid = 1'b1;
    ifa.wlast  = last;
    #1;
    chk("wready", ifa.wready, 1);
    @(negedge aclk);
    ifa.wvalid = 1'b0;
    ifa.wlast  = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [3:0] len,
                       input logic [31:0] addr);
    ifa.arvalid = 1'b1;
    ifa.arid    = id;
    ifa.arlen   = len;
    ifa.araddr  = addr;
    #1;
    chk("arready", ifa.arready, 1);
    @(negedge aclk);
    ifa.arvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] lf;
    int          m_wo, m_dp, m_b;
    logic        e_aw, e_w, e_ar, hb;
    logic [5:0]  pat;
    int          k;

    rv[0] = '{4'd3, 32'h100, 4'd3,
              '{32'h100, 32'h104, 32'h108, 32'h10C}, 2'b00};
    rv[1] = '{4'd1, 32'h8000, 4'd0,
              '{32'h8000, 32'h0, 32'h0, 32'h0}, 2'b10};
    rv[2] = '{4'd2, 32'h7FFC, 4'd0,
              '{32'h7FFC, 32'h0, 32'h0, 32'h0}, 2'b00};
    rv[3] = '{4'd7, 32'hFFFF_FFF8, 4'd2,
              '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h0}, 2'b10};

    wv[0] = '{4'd5, 32'h0,    4'd1, 2, 1,  2'b00};
    wv[1] = '{4'd5, 32'h0,    4'd1, 1, 0,  2'b10};
    wv[2] = '{4'd2, 32'h10,   4'd0, 1, 0,  2'b00};
    wv[3] = '{4'd9, 32'h20,   4'd2, 3, -1, 2'b10};
    wv[4] = '{4'd4, 32'h8000, 4'd0, 1, 0,  2'b10};
    wv[5] = '{4'd6, 32'h7FFC, 4'd3, 4, 3,  2'b00};

    ifa.awvalid = 0; ifa.awid = 0; ifa.awaddr = 0; ifa.awlen = 0;
    ifa.wvalid = 0; ifa.wlast = 0; ifa.bready = 0;
    ifa.arvalid = 0; ifa.arid = 0; ifa.araddr = 0; ifa.arlen = 0;
    ifa.rready = 0;

    ifb.awvalid = 1; ifb.awid = 0; ifb.awaddr = 0; ifb.awlen = 0;
    ifb.wvalid = 1; ifb.wlast = 1; ifb.bready = 1;
    ifb.arvalid = 1; ifb.arid = 0; ifb.araddr = 0; ifb.arlen = 0;
    ifb.rready = 1;

    repeat (3) @(negedge aclk);
    #1;
    chk("rst_awready", ifa.awready, 0);
    chk("rst_wready", ifa.wready, 0);
    chk("rst_arready", ifa.arready, 0);
    chk("rst_bvalid", ifa.bvalid, 0);
    chk("rst_rvalid", ifa.rvalid, 0);
    chk("rst_rlast", ifa.rlast, 0);
    chk("rst_ostd", {wr_ostd_a, rd_ostd_a}, 0);
    chk("rst_bid_rdata", {ifa.bid, ifa.bresp, ifa.rdata, ifa.rid}, 0);
    chk("rst_b_readies",
        {ifb.awready, ifb.wready, ifb.arready}, 0);

    // LFSR-throttled readies, tracked by a small occupancy model.
    @(negedge aclk);
    aresetn = 1'b1;
    lf = 16'hACE1;
    m_wo = 0; m_dp = 0; m_b = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      e_aw = lf[0] && (m_wo < 4);
      e_w  = lf[5] && (m_dp > 0);
      e_ar = lf[10];
      chk("lfsr_readies",
          {ifb.awready, ifb.wready, ifb.arready},
          {e_aw, e_w, e_ar});
      hb = (m_b > 0);
      m_wo = m_wo + int'(e_aw) - int'(hb);
      m_dp = m_dp + int'(e_aw) - int'(e_w);
      m_b  = m_b + int'(e_w) - int'(hb);
      lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
      @(negedge aclk);
    end

    // Read bursts from the vector table.
    for (int i = 0; i < 4; i++) begin
      do_ar(rv[i].id, rv[i].len, rv[i].addr);
      ifa.rready = 1'b1;
      for (int b = 0; b <= int'(rv[i].len); b++) begin
        #1;
        chk("r_valid", ifa.rvalid, 1);
        chk("r_data", ifa.rdata, rv[i].d[b]);
        chk("r_id", ifa.rid, rv[i].id);
        chk("r_resp", ifa.rresp, rv[i].resp);
        chk("r_last", ifa.rlast, (b == int'(rv[i].len)));
        @(negedge aclk);
      end
      ifa.rready = 1'b0;
      #1;
      chk("r_idle", {ifa.rvalid, rd_ostd_a}, 0);
    end

    // Write bursts from the vector table.
    for (int i = 0; i < 6; i++) begin
      do_aw(wv[i].id, wv[i].len, wv[i].addr);
      for (int b = 0; b < wv[i].nbeats; b++) begin
        do_w(b == wv[i].lastpos);
      end
      #1;
      chk("b_valid", ifa.bvalid, 1);
      chk("b_id", ifa.bid, wv[i].id);
      chk("b_resp", ifa.bresp, wv[i].resp);
      ifa.bready = 1'b1;
      @(negedge aclk);
      ifa.bready = 1'b0;
      #1;
      chk("b_idle", {ifa.bvalid, wr_ostd_a}, 0);
    end

    // R outputs hold while rready is low.
    @(negedge aclk);
    do_ar(4'hA, 4'd2, 32'h40);
    pat = 6'b110010;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      ifa.rready = pat[c];
      #1;
      chk("hold_valid", ifa.rvalid, 1);
      chk("hold_data", ifa.rdata, 32'h40 + 32'(k * 4));
      chk("hold_last", ifa.rlast, (k == 2));
      chk("hold_id", ifa.rid, 4'hA);
      @(negedge aclk);
      if (pat[c]) k++;
    end
    ifa.rready = 1'b0;
    #1;
    chk("hold_done", {ifa.rvalid, rd_ostd_a}, 0);

    // Outstanding write limit and same-cycle AW+B.
    @(negedge aclk);
    for (int i = 0; i < 4; i++) begin
      do_aw(4'(i), 4'd0, 32'h0);
    end
    #1;
    chk("wr_ostd_full", wr_ostd_a, 4);
    ifa.awvalid = 1'b1;
    ifa.awid = 4'd4;
    #1;
    chk("aw_full_ready", ifa.awready, 0);
    ifa.awvalid = 1'b0;
    @(negedge aclk);
    do_w(1'b1);
    #1;
    chk("full_bvalid", ifa.bvalid, 1);
    chk("full_bid", ifa.bid, 0);
    ifa.awvalid = 1'b1;
    ifa.bready = 1'b1;
    #1;
    chk("aw_pre_edge", ifa.awready, 0);
    @(negedge aclk);
    ifa.awvalid = 1'b0;
    ifa.bready = 1'b0;
    #1;
    chk("wr_ostd_after_b", wr_ostd_a, 3);
    chk("aw_return", ifa.awready, 1);
    do_w(1'b1);
    #1;
    chk("b1_valid", ifa.bvalid, 1);
    chk("b1_id", ifa.bid, 1);
    ifa.awvalid = 1'b1;
    ifa.awid = 4'd4;
    ifa.bready = 1'b1;
    #1;
    chk("aw_b_same_ready", ifa.awready, 1);
    @(negedge aclk);
    ifa.awvalid = 1'b0;
    ifa.bready = 1'b0;
    #1;
    chk("aw_b_same_ostd", wr_ostd_a, 3);
    repeat (3) do_w(1'b1);
    ifa.bready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_bvalid", ifa.bvalid, 1);
      chk("drain_bid", ifa.bid, 2 + i);
      @(negedge aclk);
    end
    ifa.bready = 1'b0;
    #1;
    chk("drain_idle", {ifa.bvalid, wr_ostd_a}, 0);

    // Reset in the middle of a read burst.
    @(negedge aclk);
    do_ar(4'd5, 4'd3, 32'h200);
    ifa.rready = 1'b1;
    #1;
    chk("mid_beat0", ifa.rdata, 32'h200);
    @(negedge aclk);
    #1;
    chk("mid_beat1", ifa.rdata, 32'h204);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_rvalid", ifa.rvalid, 0);
    chk("mid_rst_rlast", ifa.rlast, 0);
    chk("mid_rst_arready", ifa.arready, 0);
    chk("mid_rst_ostd", rd_ostd_a, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    do_ar(4'd6, 4'd0, 32'h300);
    #1;
    chk("post_rst_rvalid", ifa.rvalid, 1);
    chk("post_rst_rdata", ifa.rdata, 32'h300);
    chk("post_rst_rid", ifa.rid, 6);
    chk("post_rst_rlast", ifa.rlast, 1);
    @(negedge aclk);
    ifa.rready = 1'b0;
    #1;
    chk("post_rst_idle", rd_ostd_a, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
